seq1011_frame_tx: RTL and testbench



---
 rtl/seq1011_pkg.sv | 9 +
 rtl/seq1011_frame_tx_piso.sv | 18 +
 rtl/seq1011_frame_tx.sv | 66 ++++++
 tb/tb_seq1011_frame_tx.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/seq1011_pkg.sv
// seq1011_pkg: shared FSM states, default 1011 sync pattern/width and a max helper for the frame transmitter and detector
package seq1011_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD, GAP} state_t;
  localparam int SEQ_SYNC_W = 4;
  localparam logic [SEQ_SYNC_W-1:0] SEQ_SYNC_PAT = 4'b1011;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/seq1011_frame_tx_piso.sv
// piso_shift: parallel-in serial-out MSB-first shifter; ports clk, reset (sync active-low), load/din capture, shift, msb serial out
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);
  logic [W-1:0] q;
  always_ff @(posedge clk)
    if (!reset) q <= '0;
    else if (load) q <= din;
    else if (shift) q <= q << 1;
  assign msb = q[W-1];
endmodule

// File: rtl/seq1011_frame_tx.sv
// seq1011_frame_tx: sends each accepted word as sync+payload+gap serial frame; ports clk, reset (sync active-low), data_in/data_valid/data_ready handshake, registered dout/dout_valid/sof/busy
module seq1011_frame_tx
  import seq1011_pkg::*;
#(
  parameter int              DATA_W     = 8,
  parameter int              SYNC_W     = SEQ_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SEQ_SYNC_PAT,
  parameter int              GAP_LEN    = 2,
  parameter logic            IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              sof,
  output logic              busy
);
  localparam int CW = $clog2(max3(SYNC_W, DATA_W, GAP_LEN)) + 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic last, take, sync_bit, pay_bit, dout_n, dout_valid_n, sof_n;
  assign last = cnt == '0;
  assign data_ready = reset && (state == IDLE || (state == GAP && last));
  assign take = data_valid && data_ready;
  assign sync_bit = |(SYNC_PAT & (SYNC_W'(1) << cnt));
  always_comb begin
    state_n = state;
    cnt_n = last ? cnt : cnt - CW'(1);
    case (state)
      IDLE: if (take) begin state_n = SYNC; cnt_n = CW'(SYNC_W - 1); end
      SYNC: if (last) begin state_n = PAYLOAD; cnt_n = CW'(DATA_W - 1); end
      PAYLOAD: if (last) begin state_n = GAP; cnt_n = CW'(GAP_LEN - 1); end
      GAP: if (last) begin state_n = take ? SYNC : IDLE; cnt_n = take ? CW'(SYNC_W - 1) : '0; end
    endcase
    dout_n = state == SYNC ? sync_bit : state == PAYLOAD ? pay_bit : IDLE_LEVEL;
    dout_valid_n = state == SYNC || state == PAYLOAD;
    sof_n = state == SYNC && cnt == CW'(SYNC_W - 1);
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      dout <= IDLE_LEVEL;
      dout_valid <= 1'b0;
      sof <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dout <= dout_n;
      dout_valid <= dout_valid_n;
      sof <= sof_n;
      busy <= state_n != IDLE;
    end
  piso_shift #(.W(DATA_W)) u_piso (
    .clk(clk),
    .reset(reset),
    .load(take),
    .shift(state == PAYLOAD),
    .din(data_in),
    .msb(pay_bit)
  );
endmodule

// File: tb/tb_seq1011_frame_tx.sv
// tb_seq1011_frame_tx: directed plus random frame checks of seq1011_frame_tx against a bit-list frame model and a loopback 1011 detector
module tb_seq1011_frame_tx;
  logic clk = 1'b0, reset = 1'b0, data_valid = 1'b0;
  logic data_ready, dout, dout_valid, sof, busy;
  logic [7:0] data_in = 8'h00;
  logic [3:0] pat = 4'b1011, hist = 4'b0000;
  int errors = 0, checks = 0, rdy;
  always #5 clk = ~clk;
  seq1011_frame_tx dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .dout(dout),
    .dout_valid(dout_valid),
    .sof(sof),
    .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    hist = {hist[2:0], dout};
  endtask
  function automatic logic frame_bit(input logic [7:0] w, input int i);
    return i < 4 ? pat[3-i] : i < 12 ? w[11-i] : 1'b0;
  endfunction
  function automatic int count_1011(input logic [7:0] w);
    logic [3:0] h = 4'b0000;
    int n = 0;
    for (int i = 0; i < 14; i++) begin
      h = {h[2:0], frame_bit(w, i)};
      if (h == 4'b1011) n++;
    end
    return n;
  endfunction
  task automatic xfer(input logic [7:0] w);
    int n = 0;
    data_in = w;
    data_valid = 1'b1;
    while (!data_ready && n < 50) begin
      tick;
      n++;
    end
    chk("ready_wait", 32'(n < 50), 32'd1);
    tick;
    data_valid = 1'b0;
    data_in = ~w;
  endtask
  task automatic run_frame(input logic [7:0] w, input int drop_at, input bit noise,
                           input int abort_at, input bit loop, output int r);
    int dets = 0, pos = -1;
    r = 0;
    for (int i = 0; i < 14; i++) begin
      tick;
      chk($sformatf("dout[%0d]", i), 32'(dout), 32'(frame_bit(w, i)));
      chk($sformatf("dout_valid[%0d]", i), 32'(dout_valid), 32'(i < 12));
      chk($sformatf("sof[%0d]", i), 32'(sof), 32'(i == 0));
      if (i < 13) chk($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
      r += int'(data_ready);
      if (hist == 4'b1011) begin
        dets++;
        pos = i;
      end
      if (i == drop_at) data_valid = 1'b0;
      if (noise) begin
        data_valid = i < 11 ? 1'($urandom_range(0, 1)) : 1'b0;
        data_in = 8'($urandom);
      end
      if (i == abort_at) begin
        reset = 1'b0;
        break;
      end
    end
    if (loop) begin
      chk("loop_dets", 32'(dets), 32'd1);
      chk("loop_pos", 32'(pos), 32'd3);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    tick;
    tick;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_sof", 32'(sof), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(data_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("ready_after_rst", 32'(data_ready), 32'd1);
    xfer(8'hA5);
    chk("busy_rise", 32'(busy), 32'd1);
    run_frame(8'hA5, -1, 1'b0, -1, 1'b0, rdy);
    chk("busy_fall", 32'(busy), 32'd0);
    data_in = 8'h3C;
    data_valid = 1'b1;
    tick;
    data_in = 8'hFF;
    run_frame(8'h3C, 13, 1'b0, -1, 1'b0, rdy);
    chk("b2b_ready_cycles", 32'(rdy), 32'd1);
    chk("b2b_busy", 32'(busy), 32'd1);
    run_frame(8'hFF, -1, 1'b0, -1, 1'b0, rdy);
    chk("b2b_busy_fall", 32'(busy), 32'd0);
    xfer(8'h5A);
    run_frame(8'h5A, -1, 1'b1, -1, 1'b0, rdy);
    chk("noise_no_capture", 32'(busy), 32'd0);
    chk("noise_ready", 32'(data_ready), 32'd1);
    xfer(8'h66);
    run_frame(8'h66, -1, 1'b0, -1, 1'b0, rdy);
    xfer(8'hC3);
    run_frame(8'hC3, -1, 1'b0, 7, 1'b0, rdy);
    tick;
    chk("abort_dout", 32'(dout), 32'd0);
    chk("abort_dout_valid", 32'(dout_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sof", 32'(sof), 32'd0);
    chk("abort_ready", 32'(data_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("abort_ready_release", 32'(data_ready), 32'd1);
    xfer(8'h99);
    run_frame(8'h99, -1, 1'b0, -1, 1'b0, rdy);
    xfer(8'h0F);
    data_in = 8'hF0;
    run_frame(8'h0F, -1, 1'b0, -1, 1'b0, rdy);
    for (int f = 0; f < 20; f++) begin
      logic [7:0] w;
      do w = 8'($urandom); while (count_1011(w) != 1);
      repeat ($urandom_range(0, 2)) tick;
      xfer(w);
      run_frame(w, -1, 1'b0, -1, 1'b1, rdy);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
